// File: rtl/seven_seg_scan_driver.sv
// Six-digit common-anode 7-segment scan driver for the BCD time bus.
// Ports: clk, rst (async, active-high); s1..h2 BCD digits; blink_sel
// (00 none, 01 hours, 10 minutes, 11 seconds); dp_en separator enable;
// an[5:0], seg[6:0] (gfedcba), dp -- all active-low and registered.
module seven_seg_scan_driver #(
   parameter int DIGIT_TICKS = 100_000,
   parameter int BLANK_TICKS = 2_000,
   parameter int BLINK_TICKS = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] s1,
   input  logic [3:0] s2,
   input  logic [3:0] m1,
   input  logic [3:0] m2,
   input  logic [3:0] h1,
   input  logic [3:0] h2,
   input  logic [1:0] blink_sel,
   input  logic       dp_en,
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int TW = $clog2(DIGIT_TICKS);
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_TICKS - 1);
   localparam logic [TW-1:0] TICK_BLNK = TW'(BLANK_TICKS);
   localparam logic [BW-1:0] BLNK_LAST = BW'(BLINK_TICKS - 1);

   logic [TW-1:0] tick;
   logic [2:0]    idx;
   logic [BW-1:0] blink_cnt;
   logic          blink_ph;
   logic [23:0]   snap;

   logic          slot_end;
   logic          blank;
   logic          sel_hit;
   logic          dark;
   logic [3:0]    digit;
   logic [6:0]    seg_dec;
   logic [5:0]    an_n;
   logic [6:0]    seg_n;
   logic          dp_n;

   assign slot_end = (tick == TICK_LAST);

   // Scan position, blink timebase and frame snapshot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick      <= '0;
         idx       <= 3'd0;
         blink_cnt <= '0;
         blink_ph  <= 1'b0;
         snap      <= '0;
      end else begin
         if (slot_end) begin
            tick <= '0;
            if (idx == 3'd5) begin
               idx  <= 3'd0;
               // Whole-frame sample keeps all digits from one instant.
               snap <= {h2, h1, m2, m1, s2, s1};
            end else begin
               idx <= idx + 3'd1;
            end
         end else begin
            tick <= tick + 1'b1;
         end
         if (blink_cnt == BLNK_LAST) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      digit = 4'd0;
      unique case (idx)
         3'd0:    digit = snap[3:0];
         3'd1:    digit = snap[7:4];
         3'd2:    digit = snap[11:8];
         3'd3:    digit = snap[15:12];
         3'd4:    digit = snap[19:16];
         3'd5:    digit = snap[23:20];
         default: digit = 4'd0;
      endcase
   end

   always_comb begin
      seg_dec = 7'b0111111;
      unique case (digit)
         4'd0:    seg_dec = 7'b1000000;
         4'd1:    seg_dec = 7'b1111001;
         4'd2:    seg_dec = 7'b0100100;
         4'd3:    seg_dec = 7'b0110000;
         4'd4:    seg_dec = 7'b0011001;
         4'd5:    seg_dec = 7'b0010010;
         4'd6:    seg_dec = 7'b0000010;
         4'd7:    seg_dec = 7'b1111000;
         4'd8:    seg_dec = 7'b0000000;
         4'd9:    seg_dec = 7'b0010000;
         default: seg_dec = 7'b0111111;
      endcase
   end

   always_comb begin
      blank   = (tick < TICK_BLNK);
      sel_hit = 1'b0;
      unique case (blink_sel)
         2'b01:   sel_hit = (idx >= 3'd4);
         2'b10:   sel_hit = (idx == 3'd2) || (idx == 3'd3);
         2'b11:   sel_hit = (idx <= 3'd1);
         default: sel_hit = 1'b0;
      endcase
      // Blink darkens the digit but leaves the separator alone.
      dark  = blank || (blink_ph && sel_hit);
      an_n  = dark ? 6'b111111 : ~(6'b000001 << idx);
      seg_n = dark ? 7'b1111111 : seg_dec;
      dp_n  = ~(dp_en && !blank && ((idx == 3'd2) || (idx == 3'd4)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an  <= 6'b111111;
         seg <= 7'b1111111;
         dp  <= 1'b1;
      end else begin
         an  <= an_n;
         seg <= seg_n;
         dp  <= dp_n;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver: a cycle model queues the
// expected an/seg/dp per edge; a negedge monitor pops and compares.
module tb_seven_seg_scan_driver;

   localparam int DT = 8;
   localparam int BK = 2;
   localparam int BT = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] s1, s2, m1, m2, h1, h2;
   logic [1:0] blink_sel;
   logic       dp_en;
   logic [5:0] an;
   logic [6:0] seg;
   logic       dp;

   typedef struct packed {
      logic [5:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   exp_t        q[$];
   exp_t        me;
   int          tests = 0;
   int          fails = 0;
   int          tt = 0;
   logic [23:0] msnap = '0;
   logic [23:0] prev_in = '0;

   seven_seg_scan_driver #(
      .DIGIT_TICKS(DT),
      .BLANK_TICKS(BK),
      .BLINK_TICKS(BT)
   ) dut (
      .clk(clk), .rst(rst),
      .s1(s1), .s2(s2), .m1(m1), .m2(m2), .h1(h1), .h2(h2),
      .blink_sel(blink_sel), .dp_en(dp_en),
      .an(an), .seg(seg), .dp(dp)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] dec(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h3f;
      endcase
   endfunction

   // One clock: predict outputs for the coming edge from scan state tt.
   task automatic step();
      int         slot, ph;
      logic       blank, hit, dark;
      logic [23:0] cur;
      exp_t       e;
      cur = {h2, h1, m2, m1, s2, s1};
      if (tt > 0 && tt % (6 * DT) == 0) msnap = prev_in;
      prev_in = cur;
      slot  = (tt / DT) % 6;
      ph    = tt % DT;
      blank = (ph < BK);
      hit   = (blink_sel == 2'b01 && slot >= 4) ||
              (blink_sel == 2'b10 && (slot == 2 || slot == 3)) ||
              (blink_sel == 2'b11 && slot <= 1);
      dark  = blank || (((tt / BT) % 2 == 1) && hit);
      e.an  = dark ? 6'h3f : ~(6'b000001 << slot);
      e.seg = dark ? 7'h7f : dec(msnap[slot*4 +: 4]);
      e.dp  = !(dp_en && !blank && (slot == 2 || slot == 4));
      @(posedge clk);
      #1;
      q.push_back(e);
      tt++;
   endtask

   task automatic run_until(input int t);
      while (tt <= t) step();
   endtask

   task automatic chk(input string nm, input logic [5:0] ea,
                      input logic [6:0] es, input logic ed);
      tests++;
      if (an !== ea || seg !== es || dp !== ed) begin
         fails++;
         $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                  nm, an, seg, dp, ea, es, ed);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         me = q.pop_front();
         tests++;
         if (an !== me.an || seg !== me.seg || dp !== me.dp) begin
            fails++;
            $display("FAIL scan t=%0t: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     $time, an, seg, dp, me.an, me.seg, me.dp);
         end
      end
   end

   initial begin
      h2 = 4'd1; h1 = 4'd2; m2 = 4'd3; m1 = 4'd4; s2 = 4'd5; s1 = 4'd6;
      blink_sel = 2'b00;
      dp_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_init", 6'h3f, 7'h7f, 1'b1);
      @(negedge clk);
      rst = 1'b0;

      run_until(2);   chk("frame0_zero", 6'h3e, 7'h40, 1'b1);
      run_until(48);  chk("blank_t0", 6'h3f, 7'h7f, 1'b1);
      run_until(49);  chk("blank_t1", 6'h3f, 7'h7f, 1'b1);
      run_until(50);  chk("slot0_six", 6'h3e, 7'h02, 1'b1);
      run_until(90);  chk("slot5_one", 6'h1f, 7'h79, 1'b1);

      run_until(104);
      m1 = 4'd7;
      run_until(114); chk("m1_old", 6'h3b, 7'h19, 1'b1);
      run_until(162); chk("m1_new", 6'h3b, 7'h78, 1'b1);

      s1 = 4'hC;
      run_until(194); chk("dash", 6'h3e, 7'h3f, 1'b1);

      dp_en = 1'b1;
      run_until(208); chk("dp_blank", 6'h3f, 7'h7f, 1'b1);
      run_until(210); chk("dp_slot2", 6'h3b, 7'h78, 1'b0);
      run_until(218); chk("dp_slot3", 6'h37, 7'h30, 1'b1);
      run_until(226); chk("dp_slot4", 6'h2f, 7'h24, 1'b0);

      run_until(239);
      dp_en = 1'b0;
      blink_sel = 2'b10;
      run_until(306); chk("blink_lit", 6'h3b, 7'h78, 1'b1);
      run_until(354); chk("blink_dark", 6'h3f, 7'h7f, 1'b1);
      run_until(400);
      blink_sel = 2'b00;
      run_until(450); chk("blink_off", 6'h3b, 7'h78, 1'b1);

      run_until(508);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("rst_async", 6'h3f, 7'h7f, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      tt = 0;
      msnap = '0;
      prev_in = '0;
      run_until(2);  chk("post_rst_zero", 6'h3e, 7'h40, 1'b1);
      run_until(50); chk("post_rst_snap", 6'h3e, 7'h3f, 1'b1);
      run_until(60);
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
